keypad_scanner: RTL and testbench

//  Producer side of the keypad-to-checker path: scans a 4x4 active-low matrix keypad,

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/key_debounce.sv | 20 ++
 rtl/keypad_scanner.sv | 149 ++++++++++++++
 tb/tb_keypad_scanner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, scanner FSM states and matrix lookup helpers
package keypad_pkg;
  localparam logic [3:0] KEY_0 = 4'd0;
  localparam logic [3:0] KEY_1 = 4'd1;
  localparam logic [3:0] KEY_2 = 4'd2;
  localparam logic [3:0] KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4;
  localparam logic [3:0] KEY_5 = 4'd5;
  localparam logic [3:0] KEY_6 = 4'd6;
  localparam logic [3:0] KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8;
  localparam logic [3:0] KEY_9 = 4'd9;
  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
  localparam logic [3:0] KEY_D = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  // nibble i holds the code of row i/4, column i%4
  localparam logic [63:0] KEY_MAP = {KEY_D, KEY_HASH, KEY_0, KEY_STAR,
                                     KEY_C, KEY_9, KEY_8, KEY_7,
                                     KEY_B, KEY_6, KEY_5, KEY_4,
                                     KEY_A, KEY_3, KEY_2, KEY_1};
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_e;
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}*4 +: 4];
  endfunction
  function automatic logic [1:0] lowest_low(input logic [3:0] rows_n);
    return !rows_n[0] ? 2'd0 : !rows_n[1] ? 2'd1 : !rows_n[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: saturating count of consecutive matching cycles, done at threshold
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic system_reset,
  input  logic clear,
  input  logic match,
  output logic done
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done = cnt_q == W'(DEBOUNCE_CYCLES);
  // restart on clear or any mismatch, otherwise count up and hold at the threshold
  always_comb cnt_d = (clear || !match) ? '0 : done ? cnt_q : cnt_q + W'(1);
  // counter register
  always_ff @(posedge clk or negedge system_reset)
    if (!system_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan, debounce and key strobe; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE = 100000
) (
  input  logic       clk,
  input  logic       system_reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_clear,
  output logic       key_enter,
  output logic       key_held
);
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  state_e state_q, state_d;
  logic [3:0] sync_q, row_q, pat_q, pat_d, col_n_q, col_n_d;
  logic [3:0] key_code_q, key_code_d;
  logic [1:0] col_q, col_d, row_idx_q, row_idx_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic rep_first_q, rep_first_d, key_held_q, key_held_d;
  logic key_valid_q, key_valid_d, key_clear_q, key_clear_d, key_enter_q, key_enter_d;
  logic db_clear, db_match, db_done, fire, scan_wrap, rep_hit;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk), .system_reset(system_reset), .clear(db_clear), .match(db_match), .done(db_done)
  );
  assign col_n = col_n_q;
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_clear = key_clear_q;
  assign key_enter = key_enter_q;
  assign key_held = key_held_q;
  assign scan_wrap = scan_cnt_q == SW'(SCAN_DIV - 1);
  assign rep_hit = rep_cnt_q == (rep_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1));
  // next-state logic; rows are only trusted once the synchronizer reflects the driven column
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    col_d = col_q;
    row_idx_d = row_idx_q;
    scan_cnt_d = scan_cnt_q;
    rep_cnt_d = rep_cnt_q;
    rep_first_d = rep_first_q;
    key_held_d = key_held_q;
    key_code_d = key_code_q;
    db_clear = 1'b1;
    db_match = 1'b0;
    fire = 1'b0;
    case (state_q)
      SCAN: begin
        if (scan_cnt_q >= SW'(2) && row_q != 4'hF) begin
          state_d = PRESS_DB;
          pat_d = row_q;
          row_idx_d = lowest_low(row_q);
          scan_cnt_d = '0;
        end else begin
          scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SW'(1);
          col_d = scan_wrap ? col_q + 2'd1 : col_q;
        end
      end
      PRESS_DB: begin
        db_clear = 1'b0;
        db_match = row_q == pat_q;
        if (!db_match) begin
          state_d = SCAN;
          col_d = col_q + 2'd1;
          scan_cnt_d = '0;
        end else if (db_done) begin
          fire = 1'b1;
          key_code_d = key_lookup(row_idx_q, col_q);
          key_held_d = 1'b1;
          state_d = HELD;
          rep_cnt_d = '0;
          rep_first_d = 1'b1;
        end
      end
      HELD: begin
        state_d = row_q == 4'hF ? RELEASE_DB : HELD;
        if (REP_EN && rep_hit) begin
          fire = 1'b1;
          rep_cnt_d = '0;
          rep_first_d = 1'b0;
        end else rep_cnt_d = rep_cnt_q + RW'(rep_cnt_q != {RW{1'b1}});
      end
      default: begin
        db_clear = 1'b0;
        db_match = row_q == 4'hF;
        if (!db_match) state_d = HELD;
        else if (db_done) begin
          key_held_d = 1'b0;
          state_d = SCAN;
          col_d = 2'd0;
          scan_cnt_d = '0;
        end
      end
    endcase
    col_n_d = ~(4'b0001 << col_d);
    key_valid_d = fire;
    key_clear_d = fire && key_code_d == KEY_STAR;
    key_enter_d = fire && key_code_d == KEY_HASH;
  end
  // state, synchronizer and registered outputs
  always_ff @(posedge clk or negedge system_reset)
    if (!system_reset) begin
      state_q <= SCAN;
      sync_q <= 4'hF;
      row_q <= 4'hF;
      pat_q <= 4'hF;
      col_q <= 2'd0;
      col_n_q <= 4'b1110;
      row_idx_q <= 2'd0;
      scan_cnt_q <= '0;
      rep_cnt_q <= '0;
      rep_first_q <= 1'b0;
      key_held_q <= 1'b0;
      key_code_q <= 4'd0;
      key_valid_q <= 1'b0;
      key_clear_q <= 1'b0;
      key_enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= row_n;
      row_q <= sync_q;
      pat_q <= pat_d;
      col_q <= col_d;
      col_n_q <= col_n_d;
      row_idx_q <= row_idx_d;
      scan_cnt_q <= scan_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      key_held_q <= key_held_d;
      key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;
      key_clear_q <= key_clear_d;
      key_enter_q <= key_enter_d;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a 4x4 keypad matrix model; KEYPAD_REPEAT_EN selects repeat checks
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0] row_n, col_n, key_code;
  logic key_valid, key_clear, key_enter, key_held;
  int total = 0, bad = 0, vld_cnt = 0, ev = 0;
  logic [3:0] last_code = 4'd0;
  logic prev_vld = 1'b0;
  bit ok;
  int n_rep;
  int offs [8];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_RATE(16)) dut (
    .clk(clk), .system_reset(rst_n), .row_n(row_n), .col_n(col_n), .key_code(key_code),
    .key_valid(key_valid), .key_clear(key_clear), .key_enter(key_enter), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // key (r,c) pulls row r low while column c is driven
  always_comb
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = key_valid;
    end
  endtask

  task automatic wait_release(output bit got);
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = !key_held;
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (key_valid) begin
      vld_cnt++;
      last_code = key_code;
    end
    chk("no_back_to_back", {31'b0, key_valid & prev_vld}, 32'd0);
    chk("pulse_needs_valid", {31'b0, (key_clear | key_enter) & ~key_valid}, 32'd0);
    prev_vld = key_valid;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", col_n, 4'b1110);
    chk("rst_code", key_code, 0);
    chk("rst_outs", {key_valid, key_clear, key_enter, key_held}, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("scan_col", col_n, ~(32'd1 << ((k / 4) % 4)) & 32'hF);
    end
    repeat (68) @(negedge clk);
    chk("idle_no_strobe", vld_cnt, 0);
    keys[6] = 1'b1;
    wait_valid(ok);
    chk("six_seen", ok, 1);
    chk("six_code", key_code, 6);
    chk("six_clr_ent", {key_clear, key_enter}, 0);
    chk("six_held", key_held, 1);
    repeat (30) @(negedge clk);
    ev = 1;
    chk("six_once", vld_cnt, ev);
    chk("six_still_held", key_held, 1);
    keys[6] = 1'b0;
    repeat (9) @(negedge clk);
    chk("six_held_during_rel_db", key_held, 1);
    repeat (5) @(negedge clk);
    chk("six_released", key_held, 0);
    keys[14] = 1'b1;
    wait_valid(ok);
    chk("hash_seen", ok, 1);
    chk("hash_code", key_code, 15);
    chk("hash_enter", key_enter, 1);
    chk("hash_clear", key_clear, 0);
    keys[14] = 1'b0;
    wait_release(ok);
    chk("hash_released", ok, 1);
    keys[12] = 1'b1;
    wait_valid(ok);
    chk("star_seen", ok, 1);
    chk("star_code", key_code, 14);
    chk("star_clear", key_clear, 1);
    chk("star_enter", key_enter, 0);
    keys[12] = 1'b0;
    wait_release(ok);
    chk("star_released", ok, 1);
    ev = 3;
    chk("count_after_star", vld_cnt, ev);
    keys[9] = 1'b1;
    repeat (5) @(negedge clk);
    keys[9] = 1'b0;
    @(negedge clk);
    keys[9] = 1'b1;
    repeat (40) @(negedge clk);
    keys[9] = 1'b0;
    wait_release(ok);
    chk("bounce_released", ok, 1);
    ev = 4;
    chk("bounce_one_strobe", vld_cnt, ev);
    chk("bounce_code", last_code, 8);
    keys[5] = 1'b1;
    wait_valid(ok);
    chk("five_seen", ok, 1);
    chk("five_code", key_code, 5);
    keys[10] = 1'b1;
    repeat (20) @(negedge clk);
    keys[10] = 1'b0;
    repeat (3) @(negedge clk);
    keys[5] = 1'b0;
    repeat (3) @(negedge clk);
    keys[5] = 1'b1;
    repeat (2) @(negedge clk);
    chk("five_rel_bounce_held", key_held, 1);
    keys[5] = 1'b0;
    wait_release(ok);
    chk("five_released", ok, 1);
    ev = 5;
    chk("five_only", vld_cnt, ev);
    chk("five_last_code", last_code, 5);
    rst_n = 1'b0;
    keys[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_col", col_n, 4'b1110);
    chk("midrst_code", key_code, 0);
    chk("midrst_outs", {key_valid, key_clear, key_enter, key_held}, 0);
    keys[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_strobe", vld_cnt, ev);
    keys[0] = 1'b1;
    wait_valid(ok);
    chk("one_seen", ok, 1);
    chk("one_code", key_code, 1);
    n_rep = 0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (key_valid && n_rep < 8) begin
        offs[n_rep] = k;
        n_rep++;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    chk("rep_count", n_rep, 4);
    chk("rep_off0", offs[0], 40);
    chk("rep_off1", offs[1], 56);
    chk("rep_off2", offs[2], 72);
    chk("rep_off3", offs[3], 88);
    chk("rep_code", key_code, 1);
`else
    chk("no_repeat", n_rep, 0);
`endif
    keys[0] = 1'b0;
    wait_release(ok);
    chk("one_released", ok, 1);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
